// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the default-slave state type used by the
// address decoder / response multiplexer.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_e;

    // NONSEQ and SEQ carry data; IDLE and BUSY always get a zero-wait OKAY.
    function automatic logic is_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave for unmapped space: answers active transfers with the
// two-cycle AHB ERROR response (hready low then high, hresp high both cycles).
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic hclk,
    input  logic hresetn,
    input  logic hready,
    input  logic def_sel,
    input  logic active,
    output logic hready_d,
    output logic hresp_d
);

    ds_state_e state;
    logic      start;

    assign start = hready && def_sel && active;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values and simulation matches the synthesized logic.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state    <= DS_IDLE;
            hready_d <= 1'b1;
            hresp_d  <= HRESP_OKAY;
        end else begin
            case (state)
                DS_IDLE: begin
                    if (start) begin
                        state    <= DS_ERR1;
                        hready_d <= 1'b0;
                        hresp_d  <= HRESP_ERROR;
                    end
                end
                DS_ERR1: begin
                    state    <= DS_ERR2;
                    hready_d <= 1'b1;
                    hresp_d  <= HRESP_ERROR;
                end
                DS_ERR2: begin
                    // A new unmapped access accepted here chains straight into another error.
                    if (start) begin
                        state    <= DS_ERR1;
                        hready_d <= 1'b0;
                        hresp_d  <= HRESP_ERROR;
                    end else begin
                        state    <= DS_IDLE;
                        hready_d <= 1'b1;
                        hresp_d  <= HRESP_OKAY;
                    end
                end
                default: begin
                    state    <= DS_IDLE;
                    hready_d <= 1'b1;
                    hresp_d  <= HRESP_OKAY;
                end
            endcase
        end
    end

endmodule

// File: rtl/ahb_decoder_mux.sv
// AHB-Lite address decoder and slave-response multiplexer for NUM_SLAVES
// slaves with a programmable base/mask map and a built-in error slave.
module ahb_decoder_mux
    import ahb_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE =
        {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK =
        {32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000}
) (
    input  logic                         hclk,
    input  logic                         hresetn,
    input  logic [ADDR_W-1:0]            haddr,
    input  logic [1:0]                   htrans,
    output logic [NUM_SLAVES-1:0]        hsel,
    input  logic [NUM_SLAVES*DATA_W-1:0] hrdata_s,
    input  logic [NUM_SLAVES-1:0]        hreadyout_s,
    input  logic [NUM_SLAVES-1:0]        hresp_s,
    output logic [DATA_W-1:0]            hrdata,
    output logic                         hready,
    output logic                         hresp
);

    logic [NUM_SLAVES-1:0] match;
    logic                  def_sel;
    logic [NUM_SLAVES:0]   dsel;
    logic                  hready_d;
    logic                  hresp_d;

    for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_match
        assign match[g] = (haddr & SLV_MASK[g*ADDR_W +: ADDR_W]) == SLV_BASE[g*ADDR_W +: ADDR_W];
    end

    assign def_sel = ~|match;

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        logic found;
        hsel  = '0;
        found = 1'b0;
        // Lowest index wins on overlapping regions, keeping hsel one-hot.
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (match[i] && !found) begin
                hsel[i] = 1'b1;
                found   = 1'b1;
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            dsel <= '0;
        end else if (hready) begin
            dsel <= {def_sel, hsel};
        end
    end

    ahb_default_slave u_default_slave (
        .hclk     (hclk),
        .hresetn  (hresetn),
        .hready   (hready),
        .def_sel  (def_sel),
        .active   (is_active(htrans)),
        .hready_d (hready_d),
        .hresp_d  (hresp_d)
    );

    // dsel == 0 (after reset) falls through to an idle OKAY with ready high.
    always_comb begin
        hrdata = '0;
        hready = 1'b1;
        hresp  = HRESP_OKAY;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (dsel[i]) begin
                hrdata = hrdata_s[i*DATA_W +: DATA_W];
                hready = hreadyout_s[i];
                hresp  = hresp_s[i];
            end
        end
        if (dsel[NUM_SLAVES]) begin
            hready = hready_d;
            hresp  = hresp_d;
        end
    end

endmodule

// File: tb/tb_ahb_decoder_mux.sv
// Directed self-checking bench for ahb_decoder_mux: reset, mapped wait-state
// read, unmapped errors (single and back-to-back), idle to unmapped, overlap, async reset.
module tb_ahb_decoder_mux;

    logic         hclk;
    logic         hresetn;
    logic [31:0]  haddr;
    logic [1:0]   htrans;
    logic [3:0]   hsel;
    logic [3:0]   hsel2;
    logic [127:0] hrdata_s;
    logic [3:0]   hreadyout_s;
    logic [3:0]   hresp_s;
    logic [31:0]  hrdata;
    logic [31:0]  hrdata2;
    logic         hready;
    logic         hready2;
    logic         hresp;
    logic         hresp2;

    int total = 0;
    int bad   = 0;

    ahb_decoder_mux dut (
        .hclk        (hclk),
        .hresetn     (hresetn),
        .haddr       (haddr),
        .htrans      (htrans),
        .hsel        (hsel),
        .hrdata_s    (hrdata_s),
        .hreadyout_s (hreadyout_s),
        .hresp_s     (hresp_s),
        .hrdata      (hrdata),
        .hready      (hready),
        .hresp       (hresp)
    );

    // Overlapping map: slots 0 and 1 both claim 0x0xxx_xxxx.
    ahb_decoder_mux #(
        .SLV_BASE ({32'h3000_0000, 32'h2000_0000, 32'h0000_0000, 32'h0000_0000})
    ) dut_ovl (
        .hclk        (hclk),
        .hresetn     (hresetn),
        .haddr       (haddr),
        .htrans      (htrans),
        .hsel        (hsel2),
        .hrdata_s    (hrdata_s),
        .hreadyout_s (hreadyout_s),
        .hresp_s     (hresp_s),
        .hrdata      (hrdata2),
        .hready      (hready2),
        .hresp       (hresp2)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Default-map reference decode: top nibble 0..3 selects that slave.
    function automatic logic [3:0] ref_hsel(input logic [31:0] a);
        return (a[31:28] < 4) ? (4'b0001 << a[31:28]) : 4'b0000;
    endfunction

    // Advance to just after the next rising edge, where new inputs are driven.
    task automatic next_cycle();
        @(posedge hclk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [1:0] t);
        haddr  = a;
        htrans = t;
        #2;
    endtask

    task automatic check_rsp(input string tag, input logic rdy, input logic rsp, input logic [31:0] d);
        check({tag, "_hready"}, 64'(hready), 64'(rdy));
        check({tag, "_hresp"},  64'(hresp),  64'(rsp));
        check({tag, "_hrdata"}, 64'(hrdata), 64'(d));
    endtask

    initial begin
        hresetn     = 1'b0;
        haddr       = $urandom;
        htrans      = 2'($urandom_range(0, 3));
        hrdata_s    = {$urandom, $urandom, $urandom, $urandom};
        hreadyout_s = 4'($urandom);
        hresp_s     = 4'($urandom);
        repeat (2) @(posedge hclk);
        #3;
        check_rsp("rst", 1'b1, 1'b0, 32'h0);
        check("rst_hsel", 64'(hsel), 64'(ref_hsel(haddr)));
        haddr = 32'h1234_5678;
        #1;
        check("rst_hsel2", 64'(hsel), 64'(4'b0010));

        // Release into idle traffic to unmapped space: outputs stay at reset values.
        @(negedge hclk);
        haddr   = 32'h8000_0000;
        htrans  = 2'b00;
        hresetn = 1'b1;
        next_cycle();
        next_cycle();
        #2;
        check_rsp("post_rst", 1'b1, 1'b0, 32'h0);

        hrdata_s    = {32'h3333_3333, 32'hCAFE_F00D, 32'h1111_1111, 32'h0000_AAAA};
        hreadyout_s = 4'b1011;
        hresp_s     = 4'b0000;

        // Mapped read to slave 2 with two wait states.
        next_cycle();
        drive(32'h2000_0010, 2'b10);
        check("rd_hsel", 64'(hsel), 64'(4'b0100));
        next_cycle();
        drive(32'h0000_0000, 2'b00);
        check("rd_wait1", 64'(hready), 64'(1'b0));
        next_cycle();
        #2;
        check("rd_wait2", 64'(hready), 64'(1'b0));
        next_cycle();
        hreadyout_s = 4'b1111;
        #2;
        check_rsp("rd_done", 1'b1, 1'b0, 32'hCAFE_F00D);
        next_cycle();
        #2;
        check_rsp("rd_next_s0", 1'b1, 1'b0, 32'h0000_AAAA);

        // Single unmapped active transfer.
        drive(32'h8000_0000, 2'b10);
        check("err_hsel", 64'(hsel), 64'(4'b0000));
        next_cycle();
        drive(32'h0000_0000, 2'b00);
        check_rsp("err1", 1'b0, 1'b1, 32'h0);
        next_cycle();
        #2;
        check_rsp("err2", 1'b1, 1'b1, 32'h0);
        next_cycle();
        drive(32'h8000_0000, 2'b00);
        check_rsp("err_end", 1'b1, 1'b0, 32'h0000_AAAA);

        // Back-to-back unmapped transfers: ERR1, ERR2, ERR1, ERR2.
        drive(32'h8000_0000, 2'b10);
        next_cycle();
        drive(32'h9000_0000, 2'b11);
        check_rsp("b2b_err1a", 1'b0, 1'b1, 32'h0);
        next_cycle();
        #2;
        check_rsp("b2b_err2a", 1'b1, 1'b1, 32'h0);
        next_cycle();
        drive(32'h8000_0000, 2'b00);
        check_rsp("b2b_err1b", 1'b0, 1'b1, 32'h0);
        next_cycle();
        #2;
        check_rsp("b2b_err2b", 1'b1, 1'b1, 32'h0);

        // Idle transfers to unmapped space: zero-wait OKAY, FSM stays idle.
        next_cycle();
        #2;
        check_rsp("uidle1", 1'b1, 1'b0, 32'h0);
        next_cycle();
        drive(32'h8000_0000, 2'b01);
        check_rsp("uidle2", 1'b1, 1'b0, 32'h0);
        next_cycle();
        drive(32'h0000_0000, 2'b00);
        check_rsp("ubusy", 1'b1, 1'b0, 32'h0);

        // Overlap: lowest index wins.
        drive(32'h0000_0004, 2'b10);
        check("ovl_hsel", 64'(hsel2), 64'(4'b0001));
        check("ovl_hsel_def", 64'(hsel), 64'(4'b0001));
        drive(32'h1000_0000, 2'b00);
        check("ovl_unmapped", 64'(hsel2), 64'(4'b0000));
        check("def_map_s1", 64'(hsel), 64'(4'b0010));

        // Asynchronous reset in the middle of an error response.
        next_cycle();
        drive(32'h8000_0000, 2'b10);
        next_cycle();
        drive(32'h0000_0000, 2'b00);
        check_rsp("arst_pre", 1'b0, 1'b1, 32'h0);
        hresetn = 1'b0;
        #1;
        check_rsp("arst", 1'b1, 1'b0, 32'h0);
        @(negedge hclk);
        hresetn = 1'b1;
        next_cycle();
        #2;
        check_rsp("arst_rel", 1'b1, 1'b0, 32'h0000_AAAA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
